exmple_win_accum: RTL and testbench
===================================

Name: exmple_win_accum

Overview:
- Downstream consumer of the parallel `ldata[DSIZE-1:0]` sample produced by the example data stage.
- Sums consecutive accepted samples into fixed windows of WINDOW samples. A window can also be closed early by `in_last`.
- Each window result is queued in a 2-entry output FIFO and presented on a valid/ready interface with full back-pressure to the producer.

Parameters:
- DSIZE, 8: sample width (bits); must be ≥ 1.
- WINDOW, 4: samples per full window; must be ≥ 2.
- OSIZE, DSIZE+$clog2(WINDOW): derived localparam; sum width. Holds WINDOW*(2^DSIZE-1) exactly, so no overflow is possible.
- CSIZE, $clog2(WINDOW+1): derived localparam; sample-count width.

Ports:
- clock, input, 1: sole clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_data, input, DSIZE: sample value, unsigned.
- in_valid, input, 1: in_data valid.
- in_last, input, 1: sample closes the current window early; qualified by in_valid.
- in_ready, output, 1: registered; block can accept a sample this cycle.
- out_sum, output, OSIZE: window sum, unsigned.
- out_count, output, CSIZE: number of samples in the window, 1..WINDOW.
- out_valid, output, 1: out_sum/out_count valid.
- out_ready, input, 1: consumer accepts.
- win_total, output, 16: count of windows popped at the output; wraps modulo 2^16.

Behaviour:
- Reset (rst high, asynchronous):
  - acc=0, cnt=0, FIFO empty.
  - out_valid=0, out_sum=0, out_count=0, win_total=0.
  - in_ready=0.
- After reset release:
  - in_ready=1 from the first rising edge after rst falls.
  - Any FIFO content or partial window present at reset is discarded.
- Accept event: in_valid & in_ready at a rising edge. in_data/in_last are ignored otherwise. Upstream holds data while in_ready=0.
- Accumulator:
  - Non-closing accept: acc <= acc+in_data, cnt <= cnt+1.
  - Closing accept: cnt+1==WINDOW, or in_last=1.
    - Push {acc+in_data, cnt+1} into the FIFO.
    - Same edge: acc<=0, cnt<=0.
    - The next accepted sample starts a new window with no bubble.
  - in_last on the first sample of a window gives a window with out_count=1 and out_sum=in_data.
  - in_last on the WINDOW-th sample closes one window, not two.
- Latency: a closing accept at edge k gives out_valid=1 after edge k when the FIFO was empty. The result is visible in the cycle following the accept.
- Output FIFO:
  - 2 entries, in-order.
  - out_sum/out_count are driven from the head entry register.
  - Pop: out_valid & out_ready at a rising edge. The head advances, or out_valid drops if the FIFO becomes empty.
  - out_valid may not fall without a pop; the head entry is stable while out_valid=1 & out_ready=0.
  - Empty FIFO: out_sum/out_count hold their last values; no X.
  - Push and pop in the same edge with 1 entry: count stays 1 and the new entry becomes head.
- in_ready (registered, next-state based):
  - 0 for the next cycle when the FIFO will hold 2 entries after the edge.
  - Otherwise 1.
  - No combinational path from out_ready to in_ready. With FIFO full and a pop at edge k, in_ready returns to 1 after edge k.
  - Non-closing samples are also stalled when the FIFO is full (simplification; accepted throughput cost).
- win_total increments on every pop and wraps 0xFFFF→0x0000.
- No state machine beyond the counters. acc/cnt form the implicit states IDLE (cnt=0) and FILL (0<cnt<WINDOW).

Test Plan:
1. Basic window: WINDOW=4, DSIZE=8, out_ready=1. Send 1,2,3,4 back-to-back → one cycle after the 4th accept: out_valid=1, out_sum=10, out_count=4; win_total=1 after the pop.
2. Max value: send four samples of 255 → out_sum=1020 (10 bits), no wrap. Immediately send 5,6,7,8 → out_sum=26, with no idle cycle between windows.
3. Early close:
   - Send 9, then 7 with in_last=1 → out_sum=16, out_count=2.
   - A single sample 42 with in_last=1 → out_sum=42, out_count=1.
   - in_last on the 4th sample → exactly one result.
4. Back-pressure:
   - Hold out_ready=0 and stream 8 samples of 1 → two results queued (4,4). in_ready falls to 0 the cycle after the 2nd push; out_sum is stable at 4.
   - Raise out_ready for one cycle → in_ready=1 one cycle later. Results pop in order with no loss or duplication.
5. Reset mid-operation:
   - Accept 3 samples, with one FIFO entry pending, then pulse rst asynchronously between edges → all outputs 0 immediately; in_ready=0 during rst.
   - Release rst and send 1,1,1,1 → out_sum=4, proving no residue from the old partial window.
6. Random soak: random in_valid/out_ready/in_last over 10k cycles against a scoreboard model. Checks:
   - Sums and counts match the model.
   - The head is stable while stalled.
   - win_total equals the number of pops modulo 65536.

Source files
------------

// File: rtl/exmple_win_accum.sv
// -----------------------------------------------------------------------------
// exmple_win_accum
//   Sums consecutive accepted samples into windows of WINDOW samples (or fewer
//   when in_last closes a window early) and queues each window result in a
//   2-entry in-order FIFO presented on a valid/ready interface.
//
// Ports
//   clock     : rising-edge clock
//   rst       : asynchronous active-high reset
//   in_data   : unsigned sample
//   in_valid  : in_data valid
//   in_last   : sample closes the current window (qualified by in_valid)
//   in_ready  : registered; a sample is accepted when in_valid & in_ready
//   out_sum   : window sum from the FIFO head register
//   out_count : samples in the window, 1..WINDOW
//   out_valid : FIFO head valid
//   out_ready : consumer accepts the head
//   win_total : number of popped results, modulo 2^16
// -----------------------------------------------------------------------------
module exmple_win_accum #(
    parameter  int DSIZE  = 8,
    parameter  int WINDOW = 4,
    localparam int OSIZE  = DSIZE + $clog2(WINDOW),
    localparam int CSIZE  = $clog2(WINDOW + 1)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [DSIZE-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [OSIZE-1:0] out_sum,
    output logic [CSIZE-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      win_total
);

    logic [OSIZE-1:0] acc_q, acc_d;
    logic [CSIZE-1:0] cnt_q, cnt_d;
    logic [OSIZE-1:0] head_sum_q, head_sum_d;
    logic [CSIZE-1:0] head_cnt_q, head_cnt_d;
    logic [OSIZE-1:0] tail_sum_q, tail_sum_d;
    logic [CSIZE-1:0] tail_cnt_q, tail_cnt_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic             in_ready_q, in_ready_d;
    logic [15:0]      win_total_q, win_total_d;

    logic             accept;
    logic             closing;
    logic             pop;
    logic [OSIZE-1:0] sum_inc;
    logic [CSIZE-1:0] cnt_inc;

    assign accept  = in_valid & in_ready_q;
    assign sum_inc = acc_q + OSIZE'(in_data);
    assign cnt_inc = cnt_q + CSIZE'(1);
    // in_last on the WINDOW-th sample is the same single close event
    assign closing = accept & ((cnt_inc == CSIZE'(WINDOW)) | in_last);
    assign pop     = (fcnt_q != 2'd0) & out_ready;

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        head_sum_d  = head_sum_q;
        head_cnt_d  = head_cnt_q;
        tail_sum_d  = tail_sum_q;
        tail_cnt_d  = tail_cnt_q;
        fcnt_d      = fcnt_q;
        win_total_d = win_total_q;

        if (accept) begin
            if (closing) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum_inc;
                cnt_d = cnt_inc;
            end
        end

        // Head register always holds the oldest entry; when the FIFO drains
        // it simply keeps its last contents so the outputs never go X.
        case ({closing, pop})
            2'b10: begin
                if (fcnt_q == 2'd0) begin
                    head_sum_d = sum_inc;
                    head_cnt_d = cnt_inc;
                end else begin
                    tail_sum_d = sum_inc;
                    tail_cnt_d = cnt_inc;
                end
                fcnt_d = fcnt_q + 2'd1;
            end
            2'b01: begin
                if (fcnt_q == 2'd2) begin
                    head_sum_d = tail_sum_q;
                    head_cnt_d = tail_cnt_q;
                end
                fcnt_d = fcnt_q - 2'd1;
            end
            2'b11: begin
                if (fcnt_q == 2'd1) begin
                    head_sum_d = sum_inc;
                    head_cnt_d = cnt_inc;
                end else begin
                    head_sum_d = tail_sum_q;
                    head_cnt_d = tail_cnt_q;
                    tail_sum_d = sum_inc;
                    tail_cnt_d = cnt_inc;
                end
            end
            default: ;
        endcase

        if (pop) begin
            win_total_d = win_total_q + 16'd1;
        end

        // Registered from next-state occupancy so out_ready has no
        // combinational path to in_ready.
        in_ready_d = (fcnt_d != 2'd2);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            head_sum_q  <= '0;
            head_cnt_q  <= '0;
            tail_sum_q  <= '0;
            tail_cnt_q  <= '0;
            fcnt_q      <= '0;
            in_ready_q  <= 1'b0;
            win_total_q <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            head_sum_q  <= head_sum_d;
            head_cnt_q  <= head_cnt_d;
            tail_sum_q  <= tail_sum_d;
            tail_cnt_q  <= tail_cnt_d;
            fcnt_q      <= fcnt_d;
            in_ready_q  <= in_ready_d;
            win_total_q <= win_total_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (fcnt_q != 2'd0);
    assign out_sum   = head_sum_q;
    assign out_count = head_cnt_q;
    assign win_total = win_total_q;

endmodule

// File: tb/tb_exmple_win_accum.sv
// -----------------------------------------------------------------------------
// tb_exmple_win_accum
//   Directed and random stimulus for exmple_win_accum (DSIZE=8, WINDOW=4).
//   A negedge monitor keeps a reference model of the accumulator and a queue
//   of expected window results; entries are pushed on accepted closing
//   samples and popped/compared when the consumer takes the head.
// -----------------------------------------------------------------------------
module tb_exmple_win_accum;

    localparam int DSIZE  = 8;
    localparam int WINDOW = 4;
    localparam int OSIZE  = 10;
    localparam int CSIZE  = 3;

    logic             clock = 1'b0;
    logic             rst   = 1'b1;
    logic [DSIZE-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_last  = 1'b0;
    logic             in_ready;
    logic [OSIZE-1:0] out_sum;
    logic [CSIZE-1:0] out_count;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [15:0]      win_total;

    typedef struct {
        int unsigned sum;
        int unsigned cnt;
    } res_t;

    res_t        sb[$];
    int unsigned m_acc = 0;
    int unsigned m_cnt = 0;
    logic        m_ready = 1'b0;
    logic [15:0] m_wt = '0;
    int unsigned last_sum = 0;
    int unsigned last_cnt = 0;

    int checks = 0;
    int errors = 0;

    exmple_win_accum #(.DSIZE(DSIZE), .WINDOW(WINDOW)) dut (
        .clock    (clock),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_sum  (out_sum),
        .out_count(out_count),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .win_total(win_total)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model; inputs change at posedge+1, so negedge values are the
    // ones the DUT samples at the following rising edge.
    always @(negedge clock) begin
        res_t r;
        if (rst) begin
            sb.delete();
            m_acc    = 0;
            m_cnt    = 0;
            m_ready  = 1'b0;
            m_wt     = '0;
            last_sum = 0;
            last_cnt = 0;
        end else begin
            check("in_ready", 32'(in_ready), 32'(m_ready));
            check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            check("win_total", 32'(win_total), 32'(m_wt));
            if (sb.size() != 0) begin
                check("head_sum", 32'(out_sum), sb[0].sum);
                check("head_cnt", 32'(out_count), sb[0].cnt);
            end else begin
                check("idle_sum", 32'(out_sum), last_sum);
                check("idle_cnt", 32'(out_count), last_cnt);
            end
            if (sb.size() != 0 && out_ready) begin
                last_sum = sb[0].sum;
                last_cnt = sb[0].cnt;
                void'(sb.pop_front());
                m_wt = m_wt + 16'd1;
            end
            if (in_valid && m_ready) begin
                r.sum = m_acc + 32'(in_data);
                r.cnt = m_cnt + 1;
                if (r.cnt == WINDOW || in_last) begin
                    sb.push_back(r);
                    m_acc = 0;
                    m_cnt = 0;
                end else begin
                    m_acc = r.sum;
                    m_cnt = r.cnt;
                end
            end
            m_ready = (sb.size() != 2);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Offer one sample and return at posedge+1 of the edge that accepts it.
    task automatic send(input int unsigned d, input logic last);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = DSIZE'(d);
        in_last  = last;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            if (in_ready) done = 1'b1;
            @(posedge clock);
            #1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_win_total", 32'(win_total), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        rst = 1'b0;
        step();
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // Basic window
        out_ready = 1'b1;
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_sum", 32'(out_sum), 32'd10);
        check("t1_cnt", 32'(out_count), 32'd4);
        step();
        check("t1_win_total", 32'(win_total), 32'd1);

        // Max value, then immediate next window
        send(255, 0); send(255, 0); send(255, 0); send(255, 0);
        check("t2_max_sum", 32'(out_sum), 32'd1020);
        send(5, 0); send(6, 0); send(7, 0); send(8, 0);
        check("t2_sum", 32'(out_sum), 32'd26);
        check("t2_cnt", 32'(out_count), 32'd4);

        // Early close
        send(9, 0); send(7, 1);
        check("t3_sum2", 32'(out_sum), 32'd16);
        check("t3_cnt2", 32'(out_count), 32'd2);
        send(42, 1);
        check("t3_sum1", 32'(out_sum), 32'd42);
        check("t3_cnt1", 32'(out_count), 32'd1);
        send(1, 0); send(2, 0); send(3, 0); send(4, 1);
        check("t3_last4_sum", 32'(out_sum), 32'd10);
        check("t3_last4_cnt", 32'(out_count), 32'd4);
        step();
        check("t3_single", 32'(out_valid), 32'd0);

        // Back-pressure
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(1, 0);
        check("t4_ready_low", 32'(in_ready), 32'd0);
        check("t4_sum", 32'(out_sum), 32'd4);
        repeat (3) step();
        check("t4_stable_sum", 32'(out_sum), 32'd4);
        check("t4_stable_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t4_ready_back", 32'(in_ready), 32'd1);
        check("t4_second", 32'(out_sum), 32'd4);
        out_ready = 1'b1;
        step();
        check("t4_drained", 32'(out_valid), 32'd0);

        // Reset mid-operation
        out_ready = 1'b0;
        send(1, 0); send(1, 0); send(1, 0); send(1, 0);
        send(3, 0); send(3, 0); send(3, 0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_sum", 32'(out_sum), 32'd0);
        check("t5_cnt", 32'(out_count), 32'd0);
        check("t5_win_total", 32'(win_total), 32'd0);
        check("t5_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(1, 0); send(1, 0); send(1, 0); send(1, 0);
        check("t5_fresh_sum", 32'(out_sum), 32'd4);
        check("t5_fresh_cnt", 32'(out_count), 32'd4);

        // Random soak
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = DSIZE'($urandom);
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // One pop per cycle long enough to wrap win_total
        in_valid  = 1'b1;
        in_last   = 1'b1;
        in_data   = 8'd1;
        out_ready = 1'b1;
        repeat (65600) step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (4) step();
        check("end_drained", 32'(out_valid), 32'd0);
        check("end_win_total", 32'(win_total), 32'(m_wt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
